wb_unit: RTL

Writeback unit for the sequential Y86-64 core: the writer side of the register file's dual write port. It accepts retired instruction results (valE/valM with destinations) through a valid/ready handshake, buffers up to two results, resolves the Y86 write rules (conditional move suppression, dstE/dstM collision) and drives the register file's dstA/wrtA and dstB/wrtB ports one instruction per cycle. It also tracks machine status (running, halted, error) and stops all writes once a non-AOK instruction retires.

---
 rtl/wb_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/wb_unit.sv
// Y86-64 writeback unit: 2-entry result buffer feeding the register file's dual write port.
// Optional retired-instruction counter built when RETIRE_CNT_EN is defined.
//
// state | meaning
// RUN   | accepting and retiring results
// HALT  | HLT retired; no pushes, pops or writes until reset
// ERR   | ADR/INS retired; no pushes, pops or writes until reset
module wb_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_stat,
   input  logic        in_cnd,
   input  logic [3:0]  in_dstE,
   input  logic [3:0]  in_dstM,
   input  logic [63:0] in_valE,
   input  logic [63:0] in_valM,
   output logic [3:0]  dstA,
   output logic [63:0] wrtA,
   output logic [3:0]  dstB,
   output logic [63:0] wrtB,
   output logic [1:0]  stat,
   output logic        retire,
   output logic [63:0] retire_cnt
);
   localparam logic [1:0] DEPTH = 2'd2;
   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [1:0] SAOK  = 2'd0;
   localparam logic [1:0] SHLT  = 2'd1;

   typedef enum logic [1:0] {RUN, HALT, ERR} stateT;

   typedef struct packed {
      logic [1:0]  stat;
      logic        cnd;
      logic [3:0]  dstE;
      logic [3:0]  dstM;
      logic [63:0] valE;
      logic [63:0] valM;
   } entryT;

   stateT      state, nextState;
   logic [1:0] count;
   entryT      fifo0, fifo1, newEntry;
   logic       push, pop, headOk;
   logic [3:0] retDstA, retDstB;

   assign in_ready = (state == RUN) && (count < DEPTH);
   assign push     = in_valid && in_ready;
   assign pop      = (state == RUN) && (count != 2'd0);
   assign headOk   = (fifo0.stat == SAOK);
   assign newEntry = '{stat: in_stat, cnd: in_cnd, dstE: in_dstE, dstM: in_dstM,
                       valE: in_valE, valM: in_valM};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      if (pop && !headOk)
         nextState = (fifo0.stat == SHLT) ? HALT : ERR;
   end

   // Y86 write rules; a dstE/dstM collision lets valM win (popq %rsp)
   always_comb begin
      retDstA = fifo0.cnd ? fifo0.dstE : RNONE;
      retDstB = fifo0.dstM;
      if (retDstA == retDstB && retDstA != RNONE)
         retDstA = RNONE;
      if (!headOk) begin
         retDstA = RNONE;
         retDstB = RNONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
         fifo0 <= '0;
         fifo1 <= '0;
      end else if (pop && !headOk) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) fifo0 <= newEntry;
               else               fifo1 <= newEntry;
               count <= count + 2'd1;
            end
            2'b01: begin
               fifo0 <= fifo1;
               count <= count - 2'd1;
            end
            // push only happens below DEPTH, so a concurrent pop leaves exactly one slot
            2'b11: fifo0 <= newEntry;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dstA   <= RNONE;
         dstB   <= RNONE;
         wrtA   <= 64'd0;
         wrtB   <= 64'd0;
         stat   <= SAOK;
         retire <= 1'b0;
      end else begin
         retire <= pop;
         dstA   <= pop ? retDstA : RNONE;
         dstB   <= pop ? retDstB : RNONE;
         if (pop && headOk) begin
            wrtA <= fifo0.valE;
            wrtB <= fifo0.valM;
         end
         if (pop && !headOk)
            stat <= fifo0.stat;
      end
   end

`ifdef RETIRE_CNT_EN
   logic [63:0] retireCnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             retireCnt <= 64'd0;
      else if (pop && headOk) retireCnt <= retireCnt + 64'd1;
   end
   assign retire_cnt = retireCnt;
`else
   assign retire_cnt = 64'd0;
`endif

endmodule
